// File: rtl/regfile_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
// Shared definitions for the general-purpose register file and its users
// (decode, writeback). Holds the default register width and index width and
// the matching register index / data types.
//
// Contents:
//   DATA_W_DEF  default register width in bits
//   ADDR_W_DEF  default register index width
//   NREGS_DEF   default register count (always 1 << ADDR_W_DEF)
//   reg_idx_t   register index at the default width
//   reg_data_t  register data at the default width
// -----------------------------------------------------------------------------
package regfile_pkg;

   localparam int DATA_W_DEF = 16;
   localparam int ADDR_W_DEF = 3;
   localparam int NREGS_DEF  = 1 << ADDR_W_DEF;

   typedef logic [ADDR_W_DEF-1:0] reg_idx_t;
   typedef logic [DATA_W_DEF-1:0] reg_data_t;

endpackage : regfile_pkg

// File: rtl/rf_read_port.sv
// -----------------------------------------------------------------------------
// rf_read_port
// One combinational read port of the register file: selects a register and
// its pending bit, masks register 0 when it is hardwired to zero, and
// optionally forwards same-cycle writeback data.
//
// Build option:
//   REGFILE_BYPASS_EN  when defined, a write to the addressed register in the
//                      current cycle is forwarded (data = wr_data, busy = 0).
//
// Ports:
//   rd_addr    in   ADDR_W         register index
//   regs_flat  in   NREGS*DATA_W   all register contents, reg i at [i*DATA_W +: DATA_W]
//   pend       in   NREGS          pending bit per register
//   wr_en      in   1              writeback strobe (bypass source)
//   wr_addr    in   ADDR_W         writeback destination (bypass source)
//   wr_data    in   DATA_W         writeback data (bypass source)
//   rd_data    out  DATA_W         selected register value
//   rd_busy    out  1              selected register is pending
// -----------------------------------------------------------------------------
module rf_read_port
   import regfile_pkg::*;
#(
   parameter int DATA_W  = DATA_W_DEF,
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int NREGS   = NREGS_DEF,
   parameter int R0_ZERO = 1
) (
   input  logic [ADDR_W-1:0]       rd_addr,
   input  logic [NREGS*DATA_W-1:0] regs_flat,
   input  logic [NREGS-1:0]        pend,
   input  logic                    wr_en,
   input  logic [ADDR_W-1:0]       wr_addr,
   input  logic [DATA_W-1:0]       wr_data,
   output logic [DATA_W-1:0]       rd_data,
   output logic                    rd_busy
);

   localparam bit R0_EN = (R0_ZERO != 0);

   logic rd_is_r0;
   assign rd_is_r0 = R0_EN && (rd_addr == '0);

`ifndef REGFILE_BYPASS_EN
   // Write-side inputs only feed the bypass mux.
   logic unused_wr;
   assign unused_wr = ^{wr_en, wr_addr, wr_data};
`endif

   always_comb begin
      // NOTE: every output gets a default on entry so no path leaves it unassigned (no latch).
      rd_data = regs_flat[int'(rd_addr)*DATA_W +: DATA_W];
      rd_busy = pend[rd_addr];
`ifdef REGFILE_BYPASS_EN
      if (wr_en && (wr_addr == rd_addr)) begin
         rd_data = wr_data;
         rd_busy = 1'b0;
      end
`endif
      // Register 0 masking comes last so it also overrides a bypass to r0.
      if (rd_is_r0) begin
         rd_data = '0;
         rd_busy = 1'b0;
      end
   end

endmodule : rf_read_port

// File: rtl/regfile_scoreboard.sv
// -----------------------------------------------------------------------------
// regfile_scoreboard
// General-purpose register file for the Harvard core: two combinational read
// ports, one synchronous write port, and a per-register pending bit that
// decode sets when it issues a long-latency op (claim) and writeback clears
// when the result arrives. busy_cnt is the registered popcount of the
// pending vector.
//
// Build option:
//   REGFILE_BYPASS_EN  forward same-cycle writeback data to the read ports
//                      (handled inside rf_read_port).
//
// Ports:
//   clk         in   1         clock, rising edge
//   rst         in   1         asynchronous active-high reset
//   wr_en       in   1         writeback strobe
//   wr_addr     in   ADDR_W    writeback destination
//   wr_data     in   DATA_W    writeback data
//   rd_addr_a   in   ADDR_W    read port A index
//   rd_data_a   out  DATA_W    read port A data
//   rd_busy_a   out  1         read port A register pending
//   rd_addr_b   in   ADDR_W    read port B index
//   rd_data_b   out  DATA_W    read port B data
//   rd_busy_b   out  1         read port B register pending
//   claim_en    in   1         request to mark claim_addr pending
//   claim_addr  in   ADDR_W    destination to claim
//   claim_ok    out  1         this cycle's claim is accepted
//   busy_cnt    out  ADDR_W+1  number of pending registers
// -----------------------------------------------------------------------------
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter int DATA_W  = DATA_W_DEF,
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int NREGS   = NREGS_DEF,
   parameter int R0_ZERO = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [ADDR_W-1:0] rd_addr_a,
   output logic [DATA_W-1:0] rd_data_a,
   output logic              rd_busy_a,
   input  logic [ADDR_W-1:0] rd_addr_b,
   output logic [DATA_W-1:0] rd_data_b,
   output logic              rd_busy_b,
   input  logic              claim_en,
   input  logic [ADDR_W-1:0] claim_addr,
   output logic              claim_ok,
   output logic [ADDR_W:0]   busy_cnt
);

   localparam bit R0_EN = (R0_ZERO != 0);

   if (NREGS != (1 << ADDR_W)) begin : g_bad_nregs
      $error("regfile_scoreboard: NREGS must equal 1 << ADDR_W");
   end

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   logic [DATA_W-1:0] regs_q [NREGS];
   logic [DATA_W-1:0] regs_d [NREGS];
   logic [NREGS-1:0]  pend_q, pend_d;
   logic [ADDR_W:0]   busy_cnt_q, busy_cnt_d;

   // ---------------------------------------------------------------------------
   // Write / claim qualification
   // ---------------------------------------------------------------------------
   logic wr_is_r0, claim_is_r0;
   logic wr_eff, claim_eff;
   logic claim_same_as_wr;
   logic cnt_inc, cnt_dec;

   assign wr_is_r0         = R0_EN && (wr_addr == '0);
   assign claim_is_r0      = R0_EN && (claim_addr == '0);
   assign claim_same_as_wr = wr_en && (wr_addr == claim_addr);

   // A claim on a pending register is accepted only when writeback retires
   // that same register on this edge: the old op finishes, the new one starts.
   assign claim_ok = (claim_en && !pend_q[claim_addr]) || (claim_en && claim_same_as_wr);

   // Hardwired r0 accepts writes and claims on the bus but keeps no state.
   assign wr_eff    = wr_en && !wr_is_r0;
   assign claim_eff = claim_ok && !claim_is_r0;

   // Counter moves only when the pending vector's popcount really changes:
   // a claim that sets a clear bit, or a write that clears a set bit that is
   // not simultaneously re-claimed.
   assign cnt_inc = claim_eff && !pend_q[claim_addr];
   assign cnt_dec = wr_eff && pend_q[wr_addr] && !(claim_eff && (claim_addr == wr_addr));

   // ---------------------------------------------------------------------------
   // Next state
   // ---------------------------------------------------------------------------
   always_comb begin
      // NOTE: always_comb uses blocking assignments so the later claim update can override the write's clear of the same bit.
      regs_d     = regs_q;
      pend_d     = pend_q;
      busy_cnt_d = busy_cnt_q;

      if (wr_eff) begin
         regs_d[wr_addr] = wr_data;
         pend_d[wr_addr] = 1'b0;
      end
      // Claim is applied after the write: same-address claim wins.
      if (claim_eff) begin
         pend_d[claim_addr] = 1'b1;
      end

      if (cnt_inc && !cnt_dec) begin
         busy_cnt_d = busy_cnt_q + {{ADDR_W{1'b0}}, 1'b1};
      end else if (cnt_dec && !cnt_inc) begin
         busy_cnt_d = busy_cnt_q - {{ADDR_W{1'b0}}, 1'b1};
      end
   end

   // ---------------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------------
   // NOTE: the storage array is reset because reads after reset must return 0; this forces flops rather than a RAM macro.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREGS; i++) begin
            regs_q[i] <= '0;
         end
         pend_q     <= '0;
         busy_cnt_q <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
         regs_q     <= regs_d;
         pend_q     <= pend_d;
         busy_cnt_q <= busy_cnt_d;
      end
   end

   assign busy_cnt = busy_cnt_q;

   // ---------------------------------------------------------------------------
   // Read ports
   // ---------------------------------------------------------------------------
   logic [NREGS*DATA_W-1:0] regs_flat;

   for (genvar g = 0; g < NREGS; g++) begin : g_flat
      assign regs_flat[g*DATA_W +: DATA_W] = regs_q[g];
   end

   rf_read_port #(
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W),
      .NREGS   (NREGS),
      .R0_ZERO (R0_ZERO)
   ) u_port_a (
      .rd_addr   (rd_addr_a),
      .regs_flat (regs_flat),
      .pend      (pend_q),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .rd_data   (rd_data_a),
      .rd_busy   (rd_busy_a)
   );

   rf_read_port #(
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W),
      .NREGS   (NREGS),
      .R0_ZERO (R0_ZERO)
   ) u_port_b (
      .rd_addr   (rd_addr_b),
      .regs_flat (regs_flat),
      .pend      (pend_q),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .rd_data   (rd_data_b),
      .rd_busy   (rd_busy_b)
   );

endmodule : regfile_scoreboard
